// File: rtl/v60_fetch_decode_queue_if.sv
// Handshake bundles for the fetch/decode queue.
// The fetch bus carries beats into the queue; the decode bus carries records out of it.
interface v60_fetch_if #(
    parameter int FETCH_BYTES = 4
);
    logic                       fetch_valid;
    logic                       fetch_ready;
    logic [8*FETCH_BYTES-1:0]   fetch_data;

    modport master (output fetch_valid, output fetch_data, input  fetch_ready);
    modport slave  (input  fetch_valid, input  fetch_data, output fetch_ready);
endinterface

interface v60_dec_if #(
    parameter int PC_WIDTH = 32
);
    logic                   dec_valid;
    logic                   dec_ready;
    logic [PC_WIDTH-1:0]    dec_pc;
    logic [7:0]             dec_opcode;
    logic [7:0]             dec_modrm;
    logic [31:0]            dec_imm;
    logic [2:0]             dec_length;
    logic                   dec_illegal;

    modport master (output dec_valid, output dec_pc, output dec_opcode, output dec_modrm,
                    output dec_imm, output dec_length, output dec_illegal, input dec_ready);
    modport slave  (input  dec_valid, input  dec_pc, input  dec_opcode, input  dec_modrm,
                    input  dec_imm, input  dec_length, input  dec_illegal, output dec_ready);
endinterface

// File: rtl/v60_fetch_decode_queue.sv
// Fetch/decode front end: circular byte queue fed by fixed-width beats,
// variable-length boundary finder and one registered decode record per cycle.
module v60_fetch_decode_queue #(
    parameter int FETCH_BYTES = 4,
    parameter int QUEUE_DEPTH = 16,
    parameter int PC_WIDTH    = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic [PC_WIDTH-1:0]          flush_pc,
    v60_fetch_if.slave                   fetch,
    v60_dec_if.master                    dec,
    output logic [$clog2(QUEUE_DEPTH):0] queue_level
);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic {RUN, HALT} state_t;

    state_t              state;
    logic [7:0]          mem [QUEUE_DEPTH];
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    wr_ptr;
    logic [LVL_W-1:0]    level;
    logic [LVL_W-1:0]    level_next;
    logic [PC_WIDTH-1:0] pc;

    logic                dec_valid_q;
    logic [PC_WIDTH-1:0] dec_pc_q;
    logic [7:0]          dec_opcode_q;
    logic [7:0]          dec_modrm_q;
    logic [31:0]         dec_imm_q;
    logic [2:0]          dec_length_q;
    logic                dec_illegal_q;

    logic [7:0]          peek [5];
    logic                is_modrm;
    logic                is_illegal;
    logic [2:0]          ins_len;
    logic [31:0]         ins_imm;
    logic [7:0]          ins_modrm;
    logic                fetch_ready_c;
    logic                wr_en;
    logic                fire;

    // The opcode plus up to four trailing bytes, read straight from the head of the queue.
    for (genvar g = 0; g < 5; g++) begin : g_peek
        assign peek[g] = mem[rd_ptr + PTR_W'(g)];
    end

    always_comb begin
        is_modrm   = 1'b0;
        is_illegal = 1'b0;
        ins_len    = 3'd1;
        ins_imm    = '0;
        if (peek[0] inside {[8'h00:8'h03], [8'h08:8'h0B], [8'h28:8'h2F], [8'h88:8'h8F]}) begin
            is_modrm = 1'b1;
            unique case (peek[1][7:6])
                2'b11: ins_len = 3'd2;
                2'b01: ins_len = 3'd3;
                2'b10: ins_len = 3'd6;
                default: begin
                    if (peek[1][2:0] == 3'b100)
                        ins_len = 3'd3;
                    else if (peek[1][2:0] == 3'b101)
                        ins_len = 3'd6;
                    else
                        ins_len = 3'd2;
                end
            endcase
        end else if (peek[0] inside {[8'hB0:8'hB7], [8'h70:8'h7F], 8'hEB}) begin
            ins_len = 3'd2;
            ins_imm = {{24{peek[1][7]}}, peek[1]};
        end else if (peek[0] inside {[8'hB8:8'hBF], 8'hE9}) begin
            ins_len = 3'd5;
            ins_imm = {peek[4], peek[3], peek[2], peek[1]};
        end else if (peek[0] inside {[8'h50:8'h5F], 8'h90, 8'hF4}) begin
            ins_len = 3'd1;
        end else begin
            is_illegal = 1'b1;
        end
    end

    assign ins_modrm = is_modrm ? peek[1] : 8'h00;

    // ModR/M lengths are always >= 2, so one level test also covers "need two bytes to classify".
    assign fire = (state == RUN) && (level >= LVL_W'(ins_len)) && (!dec_valid_q || dec.dec_ready);

    assign fetch_ready_c = rst_n && (level <= LVL_W'(QUEUE_DEPTH - FETCH_BYTES));
    assign wr_en         = fetch.fetch_valid && fetch_ready_c && !flush;
    assign level_next    = level + (wr_en ? LVL_W'(FETCH_BYTES) : '0) - (fire ? LVL_W'(ins_len) : '0);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < FETCH_BYTES; i++)
                mem[wr_ptr + PTR_W'(i)] <= fetch.fetch_data[8*i +: 8];
        end
    end

    // Flush outranks fetch and decode; a beat offered on the flush edge is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= RUN;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            level         <= '0;
            pc            <= '0;
            dec_valid_q   <= 1'b0;
            dec_pc_q      <= '0;
            dec_opcode_q  <= '0;
            dec_modrm_q   <= '0;
            dec_imm_q     <= '0;
            dec_length_q  <= '0;
            dec_illegal_q <= 1'b0;
        end else if (flush) begin
            state       <= RUN;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            level       <= '0;
            pc          <= flush_pc;
            dec_valid_q <= 1'b0;
        end else begin
            level <= level_next;
            if (wr_en)
                wr_ptr <= wr_ptr + PTR_W'(FETCH_BYTES);
            if (fire) begin
                rd_ptr        <= rd_ptr + PTR_W'(ins_len);
                pc            <= pc + PC_WIDTH'(ins_len);
                dec_valid_q   <= 1'b1;
                dec_pc_q      <= pc;
                dec_opcode_q  <= peek[0];
                dec_modrm_q   <= ins_modrm;
                dec_imm_q     <= ins_imm;
                dec_length_q  <= ins_len;
                dec_illegal_q <= is_illegal;
                if (peek[0] == 8'hF4)
                    state <= HALT;
            end else if (dec.dec_ready) begin
                dec_valid_q <= 1'b0;
            end
        end
    end

    assign fetch.fetch_ready = fetch_ready_c;
    assign dec.dec_valid     = dec_valid_q;
    assign dec.dec_pc        = dec_pc_q;
    assign dec.dec_opcode    = dec_opcode_q;
    assign dec.dec_modrm     = dec_modrm_q;
    assign dec.dec_imm       = dec_imm_q;
    assign dec.dec_length    = dec_length_q;
    assign dec.dec_illegal   = dec_illegal_q;
    assign queue_level       = level;

endmodule
